// File: rtl/sig_demux_1ton.sv
`timescale 1ns/1ps
// Registered 1-to-N signal router with break-before-make guard gap; SW_COUNT exists only with SIG_DEMUX_SWCOUNT_EN.
// Latency: SYNC_STAGES+1 edges IN_SIG->OUT[ACTIVE_SEL]; SEL change reaches all-idle in 2 edges.
// No backpressure: a switchover idles every output for GAP_CYCLES periods, and SEL changes meanwhile do not extend the gap.
module sig_demux_1ton #(
    parameter int   N_OUT       = 4,
    parameter int   SEL_W       = 2,
    parameter int   SYNC_STAGES = 2,
    parameter int   GAP_CYCLES  = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_SIG,
    input  logic [SEL_W-1:0] SEL,
    output logic [N_OUT-1:0] OUT,
    output logic [SEL_W-1:0] ACTIVE_SEL,
    output logic             BUSY,
    output logic             SEL_ERR
`ifdef SIG_DEMUX_SWCOUNT_EN
    ,
    output logic [15:0]      SW_COUNT
`endif
);

    localparam int               CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(N_OUT);
    localparam logic [N_OUT-1:0] ALL_IDLE = {N_OUT{IDLE_LEVEL}};

    typedef enum logic {
        ST_ROUTE = 1'b0,
        ST_GAP   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sync_dat;
    logic [SEL_W-1:0]   sel_q;
    logic               sel_q_ok;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_OUT-1:0]   out_q, out_d;
    logic               sel_err_q;

    // Only the addressed bit carries data; every other bit stays at the idle level.
    function automatic logic [N_OUT-1:0] route(input logic [SEL_W-1:0] ch, input logic d);
        logic [N_OUT-1:0] r;
        r = ALL_IDLE;
        for (int i = 0; i < N_OUT; i++) begin
            if (ch == SEL_W'(i)) begin
                r[i] = d;
            end
        end
        return r;
    endfunction

    assign sync_dat = sync_q[SYNC_STAGES-1];
    assign sel_q_ok = ({1'b0, sel_q} < N_LIM);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= {SYNC_STAGES{IDLE_LEVEL}};
            sel_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], IN_SIG};
            sel_q     <= SEL;
            sel_err_q <= ({1'b0, SEL} >= N_LIM);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_ROUTE;
            cnt_q    <= '0;
            active_q <= '0;
            out_q    <= ALL_IDLE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        out_d    = ALL_IDLE;
        case (state_q)
            ST_ROUTE: begin
                // Out-of-range requests are ignored so the current route is held.
                if (sel_q_ok && (sel_q != active_q)) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_LOAD;
                end else begin
                    out_d = route(active_q, sync_dat);
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_ROUTE;
                    if (sel_q_ok) begin
                        active_d = sel_q;
                    end
                    out_d = route(active_d, sync_dat);
                end
            end
            default: begin
                state_d = ST_ROUTE;
            end
        endcase
    end

    assign OUT        = out_q;
    assign ACTIVE_SEL = active_q;
    assign BUSY       = (state_q == ST_GAP);
    assign SEL_ERR    = sel_err_q;

`ifdef SIG_DEMUX_SWCOUNT_EN
    logic        sw_start;
    logic [15:0] sw_cnt_q;

    assign sw_start = (state_q == ST_ROUTE) && sel_q_ok && (sel_q != active_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_cnt_q <= 16'd0;
        end else if (sw_start && (sw_cnt_q != 16'hFFFF)) begin
            sw_cnt_q <= sw_cnt_q + 16'd1;
        end
    end

    assign SW_COUNT = sw_cnt_q;
`endif

endmodule

// File: tb/tb_sig_demux_1ton.sv
`timescale 1ns/1ps
// Scoreboard bench for sig_demux_1ton: a 4-channel and a 3-channel instance share one stimulus stream.
module tb_sig_demux_1ton;

    localparam int GAP = 2;

    logic       CLK    = 1'b0;
    logic       RST_N  = 1'b0;
    logic       IN_SIG = 1'b0;
    logic [1:0] SEL    = 2'd0;

    logic [3:0] out4;
    logic [1:0] act4;
    logic       busy4, err4;
    logic [2:0] out3;
    logic [1:0] act3;
    logic       busy3, err3;
`ifdef SIG_DEMUX_SWCOUNT_EN
    logic [15:0] swc4, swc3;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int n;
        int active;
        bit gap;
        int gap_exit;
        int k;
        int sel_prev;
        bit h1;
        bit h2;
        int swc;
    } mdl_t;

    typedef struct {
        logic [3:0] out;
        int         act;
        bit         busy;
        bit         err;
        int         swc;
    } exp_t;

    mdl_t m4, m3;
    exp_t q4[$];
    exp_t q3[$];

    sig_demux_1ton #(.N_OUT(4), .SEL_W(2), .SYNC_STAGES(2), .GAP_CYCLES(GAP), .IDLE_LEVEL(1'b0)) dut4 (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_SIG     (IN_SIG),
        .SEL        (SEL),
        .OUT        (out4),
        .ACTIVE_SEL (act4),
        .BUSY       (busy4),
        .SEL_ERR    (err4)
`ifdef SIG_DEMUX_SWCOUNT_EN
        ,
        .SW_COUNT   (swc4)
`endif
    );

    sig_demux_1ton #(.N_OUT(3), .SEL_W(2), .SYNC_STAGES(2), .GAP_CYCLES(GAP), .IDLE_LEVEL(1'b0)) dut3 (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_SIG     (IN_SIG),
        .SEL        (SEL),
        .OUT        (out3),
        .ACTIVE_SEL (act3),
        .BUSY       (busy3),
        .SEL_ERR    (err3)
`ifdef SIG_DEMUX_SWCOUNT_EN
        ,
        .SW_COUNT   (swc3)
`endif
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic void mdl_reset(inout mdl_t m, input int n);
        m.n        = n;
        m.active   = 0;
        m.gap      = 1'b0;
        m.gap_exit = 0;
        m.k        = 0;
        m.sel_prev = 0;
        m.h1       = 1'b0;
        m.h2       = 1'b0;
        m.swc      = 0;
    endfunction

    // Edge k: outputs see the input sampled two edges earlier and the SEL sampled one edge earlier.
    // A switchover starting at edge k keeps everything idle until edge k+GAP, where the new route opens.
    function automatic void step(inout mdl_t m, input bit in_now, input int sel_now, output exp_t e);
        bit data;
        int selq;
        bit ok;
        m.k++;
        data = m.h2;
        selq = m.sel_prev;
        ok   = (selq < m.n);
        if (m.gap) begin
            if (m.k == m.gap_exit) begin
                m.gap = 1'b0;
                if (ok) m.active = selq;
            end
        end else if (ok && (selq != m.active)) begin
            m.gap      = 1'b1;
            m.gap_exit = m.k + GAP;
            if (m.swc < 65535) m.swc++;
        end
        e.out = 4'b0000;
        if (!m.gap) e.out[m.active] = data;
        e.act  = m.active;
        e.busy = m.gap;
        e.err  = (sel_now >= m.n);
        e.swc  = m.swc;
        m.h2       = m.h1;
        m.h1       = in_now;
        m.sel_prev = sel_now;
    endfunction

    task automatic tick(input bit in, input logic [1:0] sel, input bit rst);
        exp_t e;
        @(negedge CLK);
        IN_SIG = in;
        SEL    = sel;
        if (rst) begin
            if (RST_N) begin
                RST_N = 1'b0;
                #1;
                chk("rst_out4",  32'(out4),  32'd0);
                chk("rst_act4",  32'(act4),  32'd0);
                chk("rst_busy4", 32'(busy4), 32'd0);
                chk("rst_err4",  32'(err4),  32'd0);
                chk("rst_out3",  32'(out3),  32'd0);
                chk("rst_busy3", 32'(busy3), 32'd0);
`ifdef SIG_DEMUX_SWCOUNT_EN
                chk("rst_swc4",  32'(swc4),  32'd0);
`endif
            end
            mdl_reset(m4, 4);
            mdl_reset(m3, 3);
        end else begin
            RST_N = 1'b1;
            step(m4, in, int'(sel), e);
            q4.push_back(e);
            step(m3, in, int'(sel), e);
            q3.push_back(e);
        end
    endtask

    // Monitor: one expected record per clock edge while out of reset.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("out4",    32'(out4),  32'(e.out));
            chk("act4",    32'(act4),  32'(e.act));
            chk("busy4",   32'(busy4), 32'(e.busy));
            chk("err4",    32'(err4),  32'(e.err));
            chk("onehot4", 32'($countones(out4) <= 1), 32'd1);
`ifdef SIG_DEMUX_SWCOUNT_EN
            chk("swc4",    32'(swc4),  32'(e.swc));
`endif
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("out3",  32'(out3),  32'(e.out[2:0]));
            chk("act3",  32'(act3),  32'(e.act));
            chk("busy3", 32'(busy3), 32'(e.busy));
            chk("err3",  32'(err3),  32'(e.err));
`ifdef SIG_DEMUX_SWCOUNT_EN
            chk("swc3",  32'(swc3),  32'(e.swc));
`endif
        end
    end

    initial begin
        logic [1:0] sel_r;
        mdl_reset(m4, 4);
        mdl_reset(m3, 3);
        repeat (2) tick(1'b0, 2'd0, 1'b1);

        // Latency, then a 0->2 switch with the source held high.
        repeat (4) tick(1'b0, 2'd0, 1'b0);
        repeat (5) tick(1'b1, 2'd0, 1'b0);
        repeat (6) tick(1'b1, 2'd2, 1'b0);
        // Back to 0, then 1 followed by 3 while the gap is running.
        repeat (6) tick(1'b1, 2'd0, 1'b0);
        tick(1'b1, 2'd1, 1'b0);
        repeat (6) tick(1'b1, 2'd3, 1'b0);
        // Channel 3 is out of range on the 3-channel instance.
        repeat (4) tick(1'b0, 2'd3, 1'b0);
        // Return to the old channel mid-gap.
        tick(1'b1, 2'd1, 1'b0);
        repeat (5) tick(1'b1, 2'd3, 1'b0);
        // Reset while the gap is active.
        repeat (2) tick(1'b1, 2'd0, 1'b0);
        repeat (2) tick(1'b1, 2'd0, 1'b1);
        repeat (4) tick(1'b1, 2'd0, 1'b0);

        sel_r = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                repeat (2) tick(1'b0, sel_r, 1'b1);
            end
            if ($urandom_range(0, 4) == 0) sel_r = 2'($urandom_range(0, 3));
            tick(1'($urandom_range(0, 1)), sel_r, 1'b0);
        end

        repeat (3) @(posedge CLK);
        #2;
        chk("drain4", 32'(q4.size()), 32'd0);
        chk("drain3", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
